wb_arbiter: RTL

- Shares the core's single register-file write port (wenable/wfmode/wreg/wdata) among NREQ writeback requesters, e.g. ALU, FPU and load unit.
- Arbitration is round-robin.
- Keeps a 64-entry busy scoreboard (32 greg + 32 freg) so decode can stall on pending destinations.
- Sits between the execution units and the core's register-file write inputs.

---
 rtl/wb_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter for the shared register-file write port,
// with a 64-entry destination busy scoreboard for decode hazard checks.
module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_fmode,
  input  logic [5*NREQ-1:0] req_reg,
  input  logic [32*NREQ-1:0] req_data,
  input  logic              issue_en,
  input  logic              issue_fmode,
  input  logic [4:0]        issue_reg,
  input  logic              chk_fmode,
  input  logic [4:0]        chk_reg1,
  input  logic [4:0]        chk_reg2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              wenable,
  output logic              wfmode,
  output logic [4:0]        wreg,
  output logic [31:0]       wdata,
  output logic [IW-1:0]     grant_id,
  output logic [6:0]        busy_count
);

  logic [IW-1:0] rr_ptr_r;
  logic [IW:0]   cand_s;
  logic [IW:0]   wrap_s;
  logic          found_s;
  logic [IW-1:0] win_s;
  logic [IW-1:0] nxt_ptr_s;
  logic [NREQ-1:0] ready_s;
  logic          win_fmode_s;
  logic [4:0]    win_reg_s;
  logic [31:0]   win_data_s;
  logic [63:0]   sb_r;
  logic [63:0]   sb_next_s;
  logic          wenable_r;
  logic          wfmode_r;
  logic [4:0]    wreg_r;
  logic [31:0]   wdata_r;
  logic [IW-1:0] grant_id_r;
  logic [6:0]    busy_count_r;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  // greg 0 is hard-wired, so it never reports a hazard
  function automatic logic hazard(input logic f, input logic [4:0] r);
    logic hit;
    if (!f && (r == 5'd0)) begin
      hit = 1'b0;
    end else begin
      hit = sb_r[{f, r}] | (wenable_r & (wfmode_r == f) & (wreg_r == r));
    end
    return hit;
  endfunction

  // Round-robin search starting at the pointer, wrapping modulo NREQ
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (IW+1)'(i);
      if (cand_s >= (IW+1)'(NREQ)) begin
        cand_s = cand_s - (IW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_valid[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant and next pointer derived from the winner
  always_comb begin
    ready_s = '0;
    wrap_s  = {1'b0, win_s} + {{IW{1'b0}}, 1'b1};
    if (found_s) begin
      ready_s[win_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
    if (wrap_s == (IW+1)'(NREQ)) begin
      nxt_ptr_s = '0;
    end else begin
      nxt_ptr_s = wrap_s[IW-1:0];
    end
  end

  assign req_ready   = ready_s;
  assign win_fmode_s = req_fmode[win_s];
  assign win_reg_s   = req_reg[int'(win_s)*5 +: 5];
  assign win_data_s  = req_data[int'(win_s)*32 +: 32];

  // Scoreboard update: clear on accept first so a same-edge issue wins
  always_comb begin
    sb_next_s = sb_r;
    if (found_s) begin
      sb_next_s[{win_fmode_s, win_reg_s}] = 1'b0;
    end else begin
      sb_next_s = sb_r;
    end
    if (issue_en && (issue_fmode || (issue_reg != 5'd0))) begin
      sb_next_s[{issue_fmode, issue_reg}] = 1'b1;
    end else begin
      sb_next_s = sb_next_s;
    end
  end

  // Write-port, pointer and scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r     <= '0;
      sb_r         <= 64'd0;
      busy_count_r <= 7'd0;
      wenable_r    <= 1'b0;
      wfmode_r     <= 1'b0;
      wreg_r       <= 5'd0;
      wdata_r      <= 32'd0;
      grant_id_r   <= '0;
    end else begin
      sb_r         <= sb_next_s;
      busy_count_r <= popcount64(sb_next_s);
      wenable_r    <= found_s;
      if (found_s) begin
        rr_ptr_r   <= nxt_ptr_s;
        wfmode_r   <= win_fmode_s;
        wreg_r     <= win_reg_s;
        wdata_r    <= win_data_s;
        grant_id_r <= win_s;
      end else begin
        rr_ptr_r   <= rr_ptr_r;
        wfmode_r   <= wfmode_r;
        wreg_r     <= wreg_r;
        wdata_r    <= wdata_r;
        grant_id_r <= grant_id_r;
      end
    end
  end

  assign chk_busy1  = hazard(chk_fmode, chk_reg1);
  assign chk_busy2  = hazard(chk_fmode, chk_reg2);
  assign wenable    = wenable_r;
  assign wfmode     = wfmode_r;
  assign wreg       = wreg_r;
  assign wdata      = wdata_r;
  assign grant_id   = grant_id_r;
  assign busy_count = busy_count_r;

endmodule
